osc_phase_gen: RTL

OSC_PHASE_GEN -- requirements
Module: osc_phase_gen

---
 rtl/osc_phase_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/osc_phase_gen.sv
// osc_phase_gen
// Programmable square-wave divider with a one-hot phase rotator.
//
// A half-period counter runs from 0 up to div_q. Reaching div_q is a "wrap":
// the counter returns to 0 and y toggles. Each wrap also applies any pending
// divisor. Dropping en does not cut the output short. The block drains until
// y is back at 0, and only then parks in HALT.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   en        : run request
//   div_in    : new divisor value (half-period = div_in+1 clk cycles)
//   div_load  : one-cycle strobe that captures div_in as the pending divisor
//   div_ack   : one-cycle pulse on the edge where a pending divisor takes effect
//   y         : divided square wave (registered)
//   tick      : one-cycle pulse on every y transition (registered)
//   phase     : one-hot phase, rotates left on every rising edge of y
//   stopped   : high while the FSM sits in HALT
module osc_phase_gen #(
    parameter int CNT_W       = 8,
    parameter int NPHASE      = 4,
    parameter int DEFAULT_DIV = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_in,
    input  logic              div_load,
    output logic              div_ack,
    output logic              y,
    output logic              tick,
    output logic [NPHASE-1:0] phase,
    output logic              stopped
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [NPHASE-1:0] PHASE_INIT = NPHASE'(1);
    localparam logic [CNT_W-1:0]  DIV_INIT   = CNT_W'(DEFAULT_DIV);

    state_t              state_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    div_q_reg;
    logic [CNT_W-1:0]    pend_val_reg;
    logic                pend_reg;
    logic                y_reg;
    logic                tick_reg;
    logic                div_ack_reg;
    logic [NPHASE-1:0]   phase_reg;

    logic                counting;
    logic                wrap;
    logic                drain_stop;
    logic                toggle;
    logic                rise;
    logic [NPHASE-1:0]   phase_next;

    // The counter only advances outside HALT. A wrap is the last cycle of a half-period.
    assign counting = (state_reg != HALT);
    assign wrap     = counting && (count_reg == div_q_reg);

    // The FSM parks only when a wrap happens in DRAIN and en is still low.
    // If en returns in DRAIN, that wrap behaves exactly like a RUN wrap.
    assign drain_stop = wrap && (state_reg == DRAIN) && !en;

    // A parking wrap toggles only if y is high. This returns y to 0 without
    // producing a spurious rising edge.
    assign toggle = wrap && (!drain_stop || y_reg);
    assign rise   = toggle && !y_reg;

    // Rotate left by one position: bit gi takes bit gi-1, and bit 0 takes the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < NPHASE; gi++) begin : g_rot
            assign phase_next[gi] = phase_reg[(gi + NPHASE - 1) % NPHASE];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= HALT;
            count_reg    <= '0;
            div_q_reg    <= DIV_INIT;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            y_reg        <= 1'b0;
            tick_reg     <= 1'b0;
            div_ack_reg  <= 1'b0;
            phase_reg    <= PHASE_INIT;
        end else begin
            tick_reg    <= toggle;
            y_reg       <= y_reg ^ toggle;
            div_ack_reg <= wrap && pend_reg;

            if (rise) begin
                phase_reg <= phase_next;
            end

            // The old pending value is applied at the wrap. A load on the same
            // edge becomes pending for the next wrap, so the newest value wins.
            if (wrap && pend_reg) begin
                div_q_reg <= pend_val_reg;
            end
            if (div_load) begin
                pend_val_reg <= div_in;
                pend_reg     <= 1'b1;
            end else if (wrap) begin
                pend_reg <= 1'b0;
            end

            if (!counting || wrap) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end

            case (state_reg)
                HALT: begin
                    if (en) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        state_reg <= RUN;
                    end else if (wrap) begin
                        state_reg <= HALT;
                    end
                end
                default: begin
                    state_reg <= HALT;
                end
            endcase
        end
    end

    assign y       = y_reg;
    assign tick    = tick_reg;
    assign div_ack = div_ack_reg;
    assign phase   = phase_reg;
    assign stopped = (state_reg == HALT);

endmodule
